// File: rtl/control_unit_seq.sv
// control_unit_seq: FETCH/DECODE/EXEC accumulator core with external program
// and data memories, built-in ALU, CALL/RET stack, sticky stack fault and
// registered flags {borrow, carry, equal, greater, lesser}.
// Optional: SINGLE_STEP_EN adds a 'step' input and a WAIT state after EXEC.
module control_unit_seq #(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 4,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [ADDR_W+3:0] imem_data,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] acc,
    output logic [4:0]        flags,
    output logic              halted,
    output logic              fault
`ifdef SINGLE_STEP_EN
    ,
    input  logic              step
`endif
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam int FL_BORROW = 4;
    localparam int FL_CARRY  = 3;
    localparam int FL_EQ     = 2;
    localparam int FL_GT     = 1;
    localparam int FL_LT     = 0;

    localparam logic [3:0] OP_HALT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                           OP_OR   = 4'h4, OP_XOR = 4'h5, OP_CMP = 4'h6, OP_JMP = 4'h7,
                           OP_JZ   = 4'h8, OP_JNZ = 4'h9, OP_CALL = 4'hA, OP_IN = 4'hB,
                           OP_LDA  = 4'hC, OP_STA = 4'hD, OP_OUT = 4'hE, OP_LDI = 4'hF;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT, S_WAIT} state_t;

`ifdef SINGLE_STEP_EN
    localparam state_t S_AFTER = S_WAIT;
`else
    localparam state_t S_AFTER = S_FETCH;
`endif

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [ADDR_W+3:0]   r_ir;
    logic [DATA_W-1:0]   r_acc;
    logic [4:0]          r_flags;
    logic [DATA_W-1:0]   r_out;
    logic [PC_W-1:0]     r_imem_addr;
    logic [ADDR_W-1:0]   r_dmem_addr;
    logic [DATA_W-1:0]   r_dmem_wdata;
    logic                r_dmem_we;
    logic                r_halted;
    logic                r_fault;
    logic [SP_W-1:0]     r_sp;
    logic [PC_W-1:0]     r_stack [STACK_DEPTH];

    // Decoded fields and datapath results used by EXEC
    logic [3:0]          w_op;
    logic [ADDR_W-1:0]   w_opnd;
    logic [DATA_W-1:0]   w_m;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_cat;
    logic [PC_W-1:0]     w_far;
    logic [PC_W-1:0]     w_near;
    logic [PC_W-1:0]     w_pc_inc;
    logic                w_is_ret;
    logic                w_acc_zero;
    logic [IDX_W-1:0]    w_push_idx;
    logic [IDX_W-1:0]    w_pop_idx;

    assign w_op       = r_ir[ADDR_W+3:ADDR_W];
    assign w_opnd     = r_ir[ADDR_W-1:0];
    assign w_m        = dmem_rdata;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_m};
    assign w_cat      = {r_acc, w_m};
    assign w_far      = w_cat[PC_W-1:0];
    assign w_near     = PC_W'(w_m);
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_is_ret   = &w_opnd;
    assign w_acc_zero = (r_acc == '0);
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));

    assign imem_addr  = r_imem_addr;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_we    = r_dmem_we;
    assign out_port   = r_out;
    assign acc        = r_acc;
    assign flags      = r_flags;
    assign halted     = r_halted;
    assign fault      = r_fault;

    // Sequencer and execute datapath; the write strobe self-clears every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_FETCH;
            r_pc         <= '0;
            r_ir         <= '0;
            r_acc        <= '0;
            r_flags      <= '0;
            r_out        <= '0;
            r_imem_addr  <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_sp         <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else begin
            r_dmem_we <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_imem_addr <= r_pc;
                    r_state     <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir        <= imem_data;
                    r_dmem_addr <= imem_data[ADDR_W-1:0];
                    r_state     <= S_EXEC;
                end
                S_EXEC: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_AFTER;
                    case (w_op)
                        OP_HALT: begin
                            r_pc     <= r_pc;
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                        OP_ADD: begin
                            r_acc            <= w_sum[DATA_W-1:0];
                            r_flags[FL_CARRY] <= w_sum[DATA_W];
                        end
                        OP_SUB: begin
                            r_acc              <= r_acc - w_m;
                            r_flags[FL_BORROW] <= (r_acc < w_m);
                        end
                        OP_AND: r_acc <= r_acc & w_m;
                        OP_OR:  r_acc <= r_acc | w_m;
                        OP_XOR: r_acc <= r_acc ^ w_m;
                        OP_CMP: begin
                            r_flags[FL_LT] <= (r_acc < w_m);
                            r_flags[FL_GT] <= (r_acc > w_m);
                            r_flags[FL_EQ] <= (r_acc == w_m);
                        end
                        OP_JMP: r_pc <= w_far;
                        OP_JZ:  if (w_acc_zero)  r_pc <= w_near;
                        OP_JNZ: if (!w_acc_zero) r_pc <= w_near;
                        OP_CALL: begin
                            // Stack misuse freezes the core at the offending instruction
                            if (w_is_ret) begin
                                if (r_sp == '0) begin
                                    r_pc     <= r_pc;
                                    r_fault  <= 1'b1;
                                    r_halted <= 1'b1;
                                    r_state  <= S_HALT;
                                end else begin
                                    r_pc <= r_stack[w_pop_idx];
                                    r_sp <= r_sp - SP_W'(1);
                                end
                            end else if (r_sp == SP_W'(STACK_DEPTH)) begin
                                r_pc     <= r_pc;
                                r_fault  <= 1'b1;
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end else begin
                                r_stack[w_push_idx] <= w_pc_inc;
                                r_sp                <= r_sp + SP_W'(1);
                                r_pc                <= w_far;
                            end
                        end
                        OP_IN: begin
                            r_dmem_wdata <= in_port;
                            r_dmem_we    <= 1'b1;
                        end
                        OP_LDA: r_acc <= w_m;
                        OP_STA: begin
                            r_dmem_wdata <= r_acc;
                            r_dmem_we    <= 1'b1;
                        end
                        OP_OUT: r_out <= w_m;
                        OP_LDI: r_acc <= DATA_W'(w_opnd);
                    endcase
                end
`ifdef SINGLE_STEP_EN
                S_WAIT: if (step) r_state <= S_FETCH;
`endif
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_seq.sv
// Scoreboard bench for control_unit_seq: an instruction-level reference model
// pushes per-instruction architectural state and expected memory writes into
// queues; monitors pop and compare on retirement and on each write strobe.
module tb_control_unit_seq;

    localparam int DW = 4, AW = 4, PW = 8, SD = 4;
`ifdef SINGLE_STEP_EN
    localparam int IPC = 4;
`else
    localparam int IPC = 3;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [PW-1:0] imem_addr;
    logic [AW+3:0] imem_data;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_rdata, dmem_wdata, in_port, out_port, acc;
    logic          dmem_we, halted, fault;
    logic [4:0]    flags;

    control_unit_seq #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .STACK_DEPTH(SD)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .in_port(in_port), .out_port(out_port),
        .acc(acc), .flags(flags), .halted(halted), .fault(fault)
`ifdef SINGLE_STEP_EN
        , .step(1'b1)
`endif
    );

    always #5 clk = ~clk;

    // Memories: combinational read, data write on the strobe
    logic [7:0] prog [256];
    logic [3:0] dmem [16];
    logic [3:0] dmem_init [16];
    logic       load = 1'b0;

    assign imem_data  = prog[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) dmem[i] <= dmem_init[i];
        end else if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
    end

    int n_edges;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n_edges <= 0;
        else          n_edges <= n_edges + 1;
    end

    typedef struct { int pc; int acc; int flags; int outp; int halted; int fault; } exp_t;
    typedef struct { int addr; int data; } wr_t;
    exp_t eq[$];
    wr_t  wq[$];
    int   n_cmp = 0, n_fail = 0, n_ret = 0;
    bit   chk_en = 1'b0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: runs the program at instruction level
    task automatic model_run(input int max_instr, input int inp);
        int a = 0, pc = 0, sp = 0, outp = 0, hlt = 0, flt = 0;
        int bor = 0, car = 0, eqf = 0, gt = 0, lt = 0;
        int op, opnd, m;
        int stk [SD];
        int dm [16];
        for (int i = 0; i < 16; i++) dm[i] = int'(dmem_init[i]);
        for (int i = 0; i < SD; i++) stk[i] = 0;
        for (int n = 0; n < max_instr && hlt == 0; n++) begin
            op   = int'(prog[pc][7:4]);
            opnd = int'(prog[pc][3:0]);
            m    = dm[opnd];
            case (op)
                0:  hlt = 1;
                1:  begin car = (a + m > 15) ? 1 : 0; a = (a + m) % 16; end
                2:  begin bor = (a < m) ? 1 : 0; a = (a - m + 16) % 16; end
                3:  a = a & m;
                4:  a = a | m;
                5:  a = a ^ m;
                6:  begin lt = (a < m) ? 1 : 0; gt = (a > m) ? 1 : 0; eqf = (a == m) ? 1 : 0; end
                11: begin dm[opnd] = inp; wq.push_back('{opnd, inp}); end
                12: a = m;
                13: begin dm[opnd] = a; wq.push_back('{opnd, a}); end
                14: outp = m;
                15: a = opnd;
                default: ;
            endcase
            case (op)
                0: ;
                7: pc = (a * 16 + m) % 256;
                8: pc = (a == 0) ? m : (pc + 1) % 256;
                9: pc = (a != 0) ? m : (pc + 1) % 256;
                10: begin
                    if (opnd == 15) begin
                        if (sp == 0) begin flt = 1; hlt = 1; end
                        else begin sp--; pc = stk[sp]; end
                    end else if (sp == SD) begin
                        flt = 1; hlt = 1;
                    end else begin
                        stk[sp] = (pc + 1) % 256; sp++;
                        pc = (a * 16 + m) % 256;
                    end
                end
                default: pc = (pc + 1) % 256;
            endcase
            eq.push_back('{pc, a, bor * 16 + car * 8 + eqf * 4 + gt * 2 + lt, outp, hlt, flt});
        end
    endtask

    // Retirement monitor: new pc is visible on imem_addr one FETCH after EXEC
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (reset_n && chk_en && n_edges >= IPC + 1 && (n_edges % IPC) == 1 && eq.size() != 0) begin
            e = eq.pop_front();
            n_ret++;
            chk($sformatf("pc#%0d", n_ret), int'(imem_addr), e.pc);
            chk($sformatf("acc#%0d", n_ret), int'(acc), e.acc);
            chk($sformatf("flags#%0d", n_ret), int'(flags), e.flags);
            chk($sformatf("out#%0d", n_ret), int'(out_port), e.outp);
            chk($sformatf("halted#%0d", n_ret), int'(halted), e.halted);
            chk($sformatf("fault#%0d", n_ret), int'(fault), e.fault);
        end
        if (reset_n && chk_en && dmem_we) begin
            chk("write_expected", int'(wq.size() != 0), 1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("wr_addr", int'(dmem_addr), w.addr);
                chk("wr_data", int'(dmem_wdata), w.data);
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_imem_addr"}, int'(imem_addr), 0);
        chk({tag, "_dmem_addr"}, int'(dmem_addr), 0);
        chk({tag, "_dmem_wdata"}, int'(dmem_wdata), 0);
        chk({tag, "_dmem_we"}, int'(dmem_we), 0);
        chk({tag, "_out_port"}, int'(out_port), 0);
        chk({tag, "_acc"}, int'(acc), 0);
        chk({tag, "_flags"}, int'(flags), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_fault"}, int'(fault), 0);
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
        for (int i = 0; i < 16; i++) dmem_init[i] = 4'($urandom);
    endtask

    // Reset, load data memory, run the model, release and drain the scoreboard
    task automatic start_run(input int max_instr, input logic [3:0] inp);
        reset_n = 1'b0;
        chk_en  = 1'b0;
        eq.delete();
        wq.delete();
        in_port = inp;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        model_run(max_instr, int'(inp));
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        for (int c = 0; c < max_instr * IPC + 8 && eq.size() != 0; c++) @(negedge clk);
        #1;
        chk("retire_pending", eq.size(), 0);
        chk("write_pending", wq.size(), 0);
        chk_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_port = '0;
        clr_mem();
        repeat (2) @(posedge clk);
        #1 chk_reset("rst");

        // LDI 3; STA 2; LDI 5; ADD 2; HALT
        clr_mem();
        prog[0] = 8'hF3; prog[1] = 8'hD2; prog[2] = 8'hF5; prog[3] = 8'h12;
        start_run(20, 4'h0);
        chk("t1_acc", int'(acc), 8);
        chk("t1_carry", int'(flags[3]), 0);
        chk("t1_dmem2", int'(dmem[2]), 3);
        chk("t1_halted", int'(halted), 1);
        chk("t1_pc", int'(imem_addr), 4);

        // LDI F; ADD (m=1)
        clr_mem();
        dmem_init[1] = 4'h1;
        prog[0] = 8'hFF; prog[1] = 8'h11;
        start_run(20, 4'h0);
        chk("t2_acc", int'(acc), 0);
        chk("t2_carry", int'(flags[3]), 1);

        // LDI 2; SUB (m=5)
        clr_mem();
        dmem_init[5] = 4'h5;
        prog[0] = 8'hF2; prog[1] = 8'h25;
        start_run(20, 4'h0);
        chk("t3_acc", int'(acc), 13);
        chk("t3_borrow", int'(flags[4]), 1);

        // LDI 4; CMP (m=4)
        clr_mem();
        dmem_init[4] = 4'h4;
        prog[0] = 8'hF4; prog[1] = 8'h64;
        start_run(20, 4'h0);
        chk("t4_eq_gt_lt", int'(flags[2:0]), 4);
        chk("t4_acc", int'(acc), 4);

        // LDI 4; CMP (m=9)
        clr_mem();
        dmem_init[9] = 4'h9;
        prog[0] = 8'hF4; prog[1] = 8'h69;
        start_run(20, 4'h0);
        chk("t5_eq_gt_lt", int'(flags[2:0]), 1);

        // LDI 2; CALL (m=0) -> 0x20; RET returns to 2
        clr_mem();
        dmem_init[0] = 4'h0;
        prog[0] = 8'hF2; prog[1] = 8'hA0; prog[8'h20] = 8'hAF;
        start_run(20, 4'h0);
        chk("t6_pc", int'(imem_addr), 2);
        chk("t6_fault", int'(fault), 0);

        // Five nested CALLs overflow a 4-entry stack
        clr_mem();
        dmem_init[0] = 4'h0;
        prog[0] = 8'hF0; prog[1] = 8'hA0;
        start_run(20, 4'h0);
        chk("t7_fault", int'(fault), 1);
        chk("t7_halted", int'(halted), 1);
        chk("t7_pc", int'(imem_addr), 1);

        // RET with an empty stack
        clr_mem();
        prog[0] = 8'hAF;
        start_run(20, 4'h0);
        chk("t8_fault", int'(fault), 1);

        // in_port=A; IN 3; LDA 3; OUT 3
        clr_mem();
        prog[0] = 8'hB3; prog[1] = 8'hC3; prog[2] = 8'hE3;
        start_run(20, 4'hA);
        chk("t9_dmem3", int'(dmem[3]), 10);
        chk("t9_out", int'(out_port), 10);

        // LDI 0; JZ (m=6) -> 6; JNZ with acc=0 -> 7
        clr_mem();
        dmem_init[1] = 4'h6; dmem_init[2] = 4'h3;
        prog[0] = 8'hF0; prog[1] = 8'h81; prog[6] = 8'h92;
        start_run(20, 4'h0);
        chk("t10_pc", int'(imem_addr), 7);

        // Reset asserted in the EXEC cycle of STA: no write may land
        clr_mem();
        dmem_init[2] = 4'h9;
        prog[0] = 8'hF5; prog[1] = 8'hD2;
        reset_n = 1'b0;
        eq.delete();
        wq.delete();
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (IPC + 2) @(posedge clk);
        #1 chk("t11_acc_pre", int'(acc), 5);
        reset_n = 1'b0;
        #1 chk("t11_we_now", int'(dmem_we), 0);
        chk_reset("t11");
        repeat (3) @(negedge clk);
        chk("t11_dmem2_kept", int'(dmem[2]), 9);
        chk_en = 1'b0;
        start_run(20, 4'h0);
        chk("t11_dmem2_after", int'(dmem[2]), 5);

        // Randomized programs against the reference model
        for (int r = 0; r < 25; r++) begin
            clr_mem();
            for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
            start_run(40, 4'($urandom));
        end

        reset_n = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
